// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipelined MIPS core.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // FETCH:  normal issue.
  // DRAIN:  waiting out a read whose target was squashed by a redirect.
  // HALTED: no more requests until reset.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // sll $0,$0,0
  localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold keeps the contents,
// load captures a fetched word. Priority is flush > hold > load.
module if_id_reg
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load_i,
  input  logic  flush_i,
  input  logic  hold_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      npc_d   = '0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      npc_d   = npc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, handles ihit waits,
// stalls, redirects and halt, and feeds the IF/ID register.
// Memory handshake: iREN requests imemaddr; ihit=1 means imemload is valid for
// that address this cycle; the address is held stable until ihit arrives.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  word_t        imemload,
  output logic         iREN,
  output word_t        imemaddr,
  input  logic         stall,
  input  logic         redirect,
  input  word_t        redirect_pc,
  input  logic         halt_id,
  output word_t        instr_id,
  output word_t        npc_id,
  output logic         valid_id,
  output fetch_state_t state_o
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  logic         ifid_load, ifid_flush, ifid_hold;
  word_t        pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    unique case (state_q)
      FETCH: begin
        // Redirect outranks halt: a halt in ID is on the squashed path.
        if (redirect) begin
          ifid_flush = 1'b1;
          if (ihit) begin
            pc_d = redirect_pc;
          end else begin
            pend_d  = redirect_pc;
            state_d = DRAIN;
          end
        end else if (halt_id) begin
          ifid_flush = 1'b1;
          state_d    = HALTED;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else if (ihit) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        if (redirect) begin
          pend_d = redirect_pc;
        end
        // The returned word belongs to the old address and is discarded.
        if (ihit) begin
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign iREN     = (state_q != HALTED);
  assign imemaddr = pc_q;
  assign state_o  = state_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .CLK     (CLK),
    .nRST    (nRST),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .hold_i  (ifid_hold),
    .instr_i (imemload),
    .npc_i   (pc_plus4),
    .instr_o (instr_id),
    .npc_o   (npc_id),
    .valid_o (valid_id)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic         CLK;
  logic         nRST;
  logic         ihit;
  word_t        imemload;
  logic         iREN;
  word_t        imemaddr;
  logic         stall;
  logic         redirect;
  word_t        redirect_pc;
  logic         halt_id;
  word_t        instr_id;
  word_t        npc_id;
  logic         valid_id;
  fetch_state_t state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .iREN        (iREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_id     (halt_id),
    .instr_id    (instr_id),
    .npc_id      (npc_id),
    .valid_id    (valid_id),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic  nrst;
    logic  ihit;
    word_t load;
    logic  stall;
    logic  redir;
    word_t rpc;
    logic  halt;
    logic  e_iren;
    word_t e_addr;
    word_t e_instr;
    word_t e_npc;
    logic  e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic nrst, input logic ih, input word_t ld, input logic st,
                         input logic rd, input word_t rpc, input logic hl,
                         input logic e_iren, input word_t e_addr, input word_t e_instr,
                         input word_t e_npc, input logic e_valid);
    vec_t v;
    v.nrst = nrst; v.ihit = ih; v.load = ld; v.stall = st; v.redir = rd; v.rpc = rpc;
    v.halt = hl; v.e_iren = e_iren; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_npc = e_npc; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic nrst, input logic ih, input word_t ld, input logic st,
                       input logic rd, input word_t rpc, input logic hl);
    nRST = nrst; ihit = ih; imemload = ld; stall = st;
    redirect = rd; redirect_pc = rpc; halt_id = hl;
  endtask

  task automatic fill_table();
    //       nrst ih load          st rd rpc           hl  iren addr          instr         npc           v
    add_vec(0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,        32'h0,        32'h0,        0);
    // sequential fetch
    add_vec(1, 1, 32'h3C010001, 0, 0, 32'h0,        0,  1, 32'h4,        32'h3C010001, 32'h4,        1);
    add_vec(1, 1, 32'h34210002, 0, 0, 32'h0,        0,  1, 32'h8,        32'h34210002, 32'h8,        1);
    // ihit wait at 0x8
    add_vec(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,  1, 32'h8,        32'h0,        32'h0,        0);
    add_vec(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,  1, 32'h8,        32'h0,        32'h0,        0);
    add_vec(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,  1, 32'h8,        32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h24020005, 0, 0, 32'h0,        0,  1, 32'hC,        32'h24020005, 32'hC,        1);
    // stall with ihit holds everything
    add_vec(1, 1, 32'hDEADBEEF, 1, 0, 32'h0,        0,  1, 32'hC,        32'h24020005, 32'hC,        1);
    add_vec(1, 1, 32'hDEADBEEF, 1, 0, 32'h0,        0,  1, 32'hC,        32'h24020005, 32'hC,        1);
    add_vec(1, 1, 32'h00430820, 0, 0, 32'h0,        0,  1, 32'h10,       32'h00430820, 32'h10,       1);
    // redirect without ihit -> drain old read at 0x10
    add_vec(1, 0, 32'h0,        0, 1, 32'h40,       0,  1, 32'h10,       32'h0,        32'h0,        0);
    add_vec(1, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h10,       32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h11111111, 0, 0, 32'h0,        0,  1, 32'h40,       32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h8C230004, 0, 0, 32'h0,        0,  1, 32'h44,       32'h8C230004, 32'h44,       1);
    // halt is terminal; redirect ignored; reset recovers
    add_vec(1, 1, 32'h22222222, 0, 0, 32'h0,        1,  0, 32'h44,       32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h33333333, 0, 1, 32'h100,      0,  0, 32'h44,       32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h33333333, 0, 0, 32'h0,        0,  0, 32'h44,       32'h0,        32'h0,        0);
    add_vec(0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,        32'h0,        32'h0,        0);
    // redirect beats halt in the same cycle
    add_vec(1, 1, 32'h44444444, 0, 1, 32'h80,       1,  1, 32'h80,       32'h0,        32'h0,        0);
    add_vec(1, 1, 32'hAAAA0000, 0, 0, 32'h0,        0,  1, 32'h84,       32'hAAAA0000, 32'h84,       1);
    // pc wrap at the top of the address space
    add_vec(1, 1, 32'h0,        0, 1, 32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC, 32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h12345678, 0, 0, 32'h0,        0,  1, 32'h0,        32'h12345678, 32'h0,        1);
    // latest redirect in DRAIN wins; stall/halt ignored in DRAIN
    add_vec(1, 0, 32'h0,        0, 1, 32'h200,      0,  1, 32'h0,        32'h0,        32'h0,        0);
    add_vec(1, 0, 32'h0,        0, 1, 32'h300,      0,  1, 32'h0,        32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h66666666, 1, 0, 32'h0,        1,  1, 32'h300,      32'h0,        32'h0,        0);
    add_vec(1, 1, 32'h00000055, 0, 0, 32'h0,        0,  1, 32'h304,      32'h00000055, 32'h304,      1);
  endtask

  // ---------------- behavioural model ----------------
  word_t m_pc, m_pend, m_instr, m_npc;
  bit    m_valid, m_waiting_old, m_stopped;

  function automatic void m_bubble();
    m_instr = NOP_INSTR; m_npc = '0; m_valid = 1'b0;
  endfunction

  function automatic void m_reset();
    m_pc = '0; m_pend = '0; m_waiting_old = 0; m_stopped = 0; m_bubble();
  endfunction

  function automatic void m_step(input logic nrst, input logic ih, input word_t ld,
                                 input logic st, input logic rd, input word_t rpc,
                                 input logic hl);
    word_t target;
    if (!nrst) begin
      m_reset();
    end else if (m_stopped) begin
      m_bubble();
    end else if (m_waiting_old) begin
      m_bubble();
      target = rd ? rpc : m_pend;
      m_pend = target;
      if (ih) begin
        m_pc = target;
        m_waiting_old = 0;
      end
    end else if (rd) begin
      m_bubble();
      if (ih) m_pc = rpc;
      else begin
        m_pend = rpc;
        m_waiting_old = 1;
      end
    end else if (hl) begin
      m_bubble();
      m_stopped = 1;
    end else if (st) begin
      // IF/ID and pc keep their values
    end else if (ih) begin
      m_instr = ld; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_bubble();
    end
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    fetch_state_t exp_state;
    drive(0, 0, '0, 0, 0, '0, 0);
    fill_table();

    foreach (vecs[i]) begin
      drive(vecs[i].nrst, vecs[i].ihit, vecs[i].load, vecs[i].stall,
            vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d.iREN", i),     {31'd0, iREN},     {31'd0, vecs[i].e_iren});
      check($sformatf("vec%0d.imemaddr", i), imemaddr,          vecs[i].e_addr);
      check($sformatf("vec%0d.instr_id", i), instr_id,          vecs[i].e_instr);
      check($sformatf("vec%0d.npc_id", i),   npc_id,            vecs[i].e_npc);
      check($sformatf("vec%0d.valid_id", i), {31'd0, valid_id}, {31'd0, vecs[i].e_valid});
    end

    // Hand sequence: reset in the middle of a drain abandons it.
    drive(1, 0, '0, 0, 1, 32'h500, 0);
    @(posedge CLK); #1;
    check("mid_drain.state", {30'd0, state_o}, {30'd0, DRAIN});
    drive(0, 0, '0, 0, 0, '0, 0);
    @(posedge CLK); #1;
    check("mid_drain.rst_state", {30'd0, state_o}, {30'd0, FETCH});
    drive(1, 1, 32'h77777777, 0, 0, '0, 0);
    @(posedge CLK); #1;
    check("mid_drain.addr", imemaddr, 32'h4);
    check("mid_drain.instr", instr_id, 32'h77777777);

    // Randomized traffic against the model.
    drive(0, 0, '0, 0, 0, '0, 0);
    m_reset();
    @(posedge CLK); #1;
    for (int c = 0; c < 3000; c++) begin
      logic  r_nrst, r_ih, r_st, r_rd, r_hl;
      word_t r_ld, r_rpc;
      r_nrst = ($urandom_range(0, 149) != 0);
      r_ih   = ($urandom_range(0, 3) != 0);
      r_st   = ($urandom_range(0, 4) == 0);
      r_rd   = ($urandom_range(0, 7) == 0);
      r_hl   = ($urandom_range(0, 79) == 0);
      r_ld   = $urandom;
      r_rpc  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'h0000_FFFC);
      drive(r_nrst, r_ih, r_ld, r_st, r_rd, r_rpc, r_hl);
      m_step(r_nrst, r_ih, r_ld, r_st, r_rd, r_rpc, r_hl);
      @(posedge CLK); #1;
      exp_state = m_stopped ? HALTED : (m_waiting_old ? DRAIN : FETCH);
      check("rnd.iREN",     {31'd0, iREN},     {31'd0, !m_stopped});
      check("rnd.imemaddr", imemaddr,          m_pc);
      check("rnd.instr_id", instr_id,          m_instr);
      check("rnd.npc_id",   npc_id,            m_npc);
      check("rnd.valid_id", {31'd0, valid_id}, {31'd0, m_valid});
      check("rnd.state",    {30'd0, state_o},  {30'd0, exp_state});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
